stage_id: RTL and testbench

//  Instruction-decode stage of the 5-stage MIPS pipeline. Sits between the IF/ID latch (StageIF) and EX.

---
 rtl/stage_id.sv | 223 ++++++++++++++++++++++
 tb/tb_stage_id.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_id.sv
// MIPS instruction-decode stage: register file, main control decoder, load-use hazard unit, ID/EX latch.
// Optional feature: define WB_BYPASS_EN for write-through of the WB port into same-cycle register reads.
module stage_id #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           inInstruction,
    input  logic [XLEN-1:0]       inPostPc,
    input  logic                  inRegWrite,
    input  logic [REG_ADDR_W-1:0] inWriteReg,
    input  logic [XLEN-1:0]       inWriteData,
    input  logic                  inEX_Flush,
    output logic                  outPCWrite,
    output logic                  outIF_IDWrite,
    output logic                  outIF_Flush,
    output logic                  outJump,
    output logic [XLEN-1:0]       outPc,
    output logic [XLEN-1:0]       outReadData1,
    output logic [XLEN-1:0]       outReadData2,
    output logic [XLEN-1:0]       outSignExt,
    output logic [REG_ADDR_W-1:0] outRs,
    output logic [REG_ADDR_W-1:0] outRt,
    output logic [REG_ADDR_W-1:0] outRd,
    output logic                  outRegDst,
    output logic                  outAluSrc,
    output logic                  outBranch,
    output logic                  outMemRead,
    output logic                  outMemWrite,
    output logic                  outRegWrite,
    output logic                  outMemToReg,
    output logic [1:0]            outAluOp
);

    localparam int NREGS = 2 ** REG_ADDR_W;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    branch;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t                 ctrl;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rd1;
        logic [XLEN-1:0]       rd2;
        logic [XLEN-1:0]       sext;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_t;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       sext;

    assign opcode = inInstruction[31:26];
    assign rs     = inInstruction[21 +: REG_ADDR_W];
    assign rt     = inInstruction[16 +: REG_ADDR_W];
    assign rd     = inInstruction[11 +: REG_ADDR_W];
    assign sext   = {{(XLEN-16){inInstruction[15]}}, inInstruction[15:0]};

    // ------------------------------------------------------------------
    // Main control decoder
    // ------------------------------------------------------------------
    ctrl_t dec_ctrl;
    logic  dec_jump;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        dec_ctrl = '0;
        dec_jump = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl.reg_dst   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            OP_J:    dec_jump = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (inRegWrite && (inWriteReg != '0)) begin
            regs_d[inWriteReg] = inWriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this array is cleared on reset because software may read registers before writing them.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    logic byp1;
    logic byp2;

`ifdef WB_BYPASS_EN
    assign byp1 = inRegWrite && (inWriteReg != '0) && (inWriteReg == rs);
    assign byp2 = inRegWrite && (inWriteReg != '0) && (inWriteReg == rt);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    logic [XLEN-1:0] read1;
    logic [XLEN-1:0] read2;

    assign read1 = (rs == '0) ? '0 : (byp1 ? inWriteData : regs_q[rs]);
    assign read2 = (rt == '0) ? '0 : (byp2 ? inWriteData : regs_q[rt]);

    // ------------------------------------------------------------------
    // Load-use hazard detection against the instruction now in EX
    // ------------------------------------------------------------------
    id_ex_t id_ex_q;
    id_ex_t id_ex_d;
    logic   stall;

    assign stall = id_ex_q.ctrl.mem_read && (id_ex_q.rt != '0) &&
                   ((id_ex_q.rt == rs) || (id_ex_q.rt == rt));

    // A taken branch in EX must redirect even if ID would otherwise stall.
    assign outPCWrite    = ~stall | inEX_Flush;
    assign outIF_IDWrite = ~stall | inEX_Flush;
    assign outJump       = dec_jump & ~stall & ~inEX_Flush;
    assign outIF_Flush   = outJump | inEX_Flush;

    // ------------------------------------------------------------------
    // ID/EX latch
    // ------------------------------------------------------------------
    always_comb begin
        id_ex_d.pc   = inPostPc;
        id_ex_d.rd1  = read1;
        id_ex_d.rd2  = read2;
        id_ex_d.sext = sext;
        id_ex_d.rs   = rs;
        id_ex_d.rt   = rt;
        id_ex_d.rd   = rd;
        id_ex_d.ctrl = (inEX_Flush || stall) ? ctrl_t'('0) : dec_ctrl;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign outPc        = id_ex_q.pc;
    assign outReadData1 = id_ex_q.rd1;
    assign outReadData2 = id_ex_q.rd2;
    assign outSignExt   = id_ex_q.sext;
    assign outRs        = id_ex_q.rs;
    assign outRt        = id_ex_q.rt;
    assign outRd        = id_ex_q.rd;
    assign outRegDst    = id_ex_q.ctrl.reg_dst;
    assign outAluSrc    = id_ex_q.ctrl.alu_src;
    assign outBranch    = id_ex_q.ctrl.branch;
    assign outMemRead   = id_ex_q.ctrl.mem_read;
    assign outMemWrite  = id_ex_q.ctrl.mem_write;
    assign outRegWrite  = id_ex_q.ctrl.reg_write;
    assign outMemToReg  = id_ex_q.ctrl.mem_to_reg;
    assign outAluOp     = id_ex_q.ctrl.alu_op;

endmodule

// File: tb/tb_stage_id.sv
// Self-checking bench for stage_id: behavioural pipeline model compared every cycle plus directed literal checks.
module tb_stage_id;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inInstruction;
    logic [31:0] inPostPc;
    logic        inRegWrite;
    logic [4:0]  inWriteReg;
    logic [31:0] inWriteData;
    logic        inEX_Flush;
    logic        outPCWrite, outIF_IDWrite, outIF_Flush, outJump;
    logic [31:0] outPc, outReadData1, outReadData2, outSignExt;
    logic [4:0]  outRs, outRt, outRd;
    logic        outRegDst, outAluSrc, outBranch, outMemRead, outMemWrite, outRegWrite, outMemToReg;
    logic [1:0]  outAluOp;

    always #5 clk = ~clk;

    stage_id dut (
        .clk(clk), .reset(reset), .inInstruction(inInstruction), .inPostPc(inPostPc),
        .inRegWrite(inRegWrite), .inWriteReg(inWriteReg), .inWriteData(inWriteData),
        .inEX_Flush(inEX_Flush), .outPCWrite(outPCWrite), .outIF_IDWrite(outIF_IDWrite),
        .outIF_Flush(outIF_Flush), .outJump(outJump), .outPc(outPc),
        .outReadData1(outReadData1), .outReadData2(outReadData2), .outSignExt(outSignExt),
        .outRs(outRs), .outRt(outRt), .outRd(outRd), .outRegDst(outRegDst),
        .outAluSrc(outAluSrc), .outBranch(outBranch), .outMemRead(outMemRead),
        .outMemWrite(outMemWrite), .outRegWrite(outRegWrite), .outMemToReg(outMemToReg),
        .outAluOp(outAluOp)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       reg_dst, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg;
        logic [1:0] alu_op;
    } ctl_t;

    function automatic ctl_t decode(input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (op)
            6'h00: begin c.reg_dst = 1; c.reg_write = 1; c.alu_op = 2'b10; end
            6'h23: begin c.alu_src = 1; c.mem_read = 1; c.reg_write = 1; c.mem_to_reg = 1; end
            6'h2B: begin c.alu_src = 1; c.mem_write = 1; end
            6'h04: begin c.branch = 1; c.alu_op = 2'b01; end
            6'h08: begin c.alu_src = 1; c.reg_write = 1; end
            default: ;
        endcase
        return c;
    endfunction

    logic [31:0] mregs [32];
    ctl_t        m_ctl;
    logic [31:0] m_pc, m_rd1, m_rd2, m_sext;
    logic [4:0]  m_rs, m_rt, m_rd;
    bit          m_data_valid = 0;
    bit          m_ready      = 0;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (inRegWrite && inWriteReg == a) return inWriteData;
`endif
        return mregs[a];
    endfunction

    function automatic bit model_stall();
        return m_ctl.mem_read && (m_rt != 0) &&
               (m_rt == inInstruction[25:21] || m_rt == inInstruction[20:16]);
    endfunction

    always @(posedge clk) begin : model
        bit st;
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
            m_ctl = '0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_sext = 0;
            m_rs = 0; m_rt = 0; m_rd = 0;
            m_data_valid = 1;
            m_ready      = 1;
        end else if (m_ready) begin
            st = model_stall();
            if (inEX_Flush || st) begin
                m_ctl        = '0;
                m_data_valid = 0;
            end else begin
                m_ctl        = decode(inInstruction[31:26]);
                m_pc         = inPostPc;
                m_rd1        = model_read(inInstruction[25:21]);
                m_rd2        = model_read(inInstruction[20:16]);
                m_sext       = 32'($signed(inInstruction[15:0]));
                m_rs         = inInstruction[25:21];
                m_rt         = inInstruction[20:16];
                m_rd         = inInstruction[15:11];
                m_data_valid = 1;
            end
            if (inRegWrite && inWriteReg != 0) mregs[inWriteReg] = inWriteData;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit st, jmp;
        if (m_ready) begin
            st  = model_stall();
            jmp = (inInstruction[31:26] == 6'h02) && !st && !inEX_Flush;
            check("m_reg_dst",    outRegDst,   m_ctl.reg_dst);
            check("m_alu_src",    outAluSrc,   m_ctl.alu_src);
            check("m_branch",     outBranch,   m_ctl.branch);
            check("m_mem_read",   outMemRead,  m_ctl.mem_read);
            check("m_mem_write",  outMemWrite, m_ctl.mem_write);
            check("m_reg_write",  outRegWrite, m_ctl.reg_write);
            check("m_mem_to_reg", outMemToReg, m_ctl.mem_to_reg);
            check("m_alu_op",     outAluOp,    m_ctl.alu_op);
            check("m_pc_write",   outPCWrite,    !st || inEX_Flush);
            check("m_ifid_write", outIF_IDWrite, !st || inEX_Flush);
            check("m_jump",       outJump,       jmp);
            check("m_if_flush",   outIF_Flush,   jmp || inEX_Flush);
            if (m_data_valid) begin
                check("m_pc",   outPc,        m_pc);
                check("m_rd1",  outReadData1, m_rd1);
                check("m_rd2",  outReadData2, m_rd2);
                check("m_sext", outSignExt,   m_sext);
                check("m_rs",   outRs,        m_rs);
                check("m_rt",   outRt,        m_rt);
                check("m_rd",   outRd,        m_rd);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] post_pc = 32'h0000_1000;

    task automatic apply(input logic [31:0] instr, input logic wr, input logic [4:0] wreg,
                         input logic [31:0] wdata, input logic flush);
        inInstruction = instr;
        inRegWrite    = wr;
        inWriteReg    = wreg;
        inWriteData   = wdata;
        inEX_Flush    = flush;
        post_pc       = post_pc + 32'd4;
        inPostPc      = post_pc;
        #1;
    endtask

    task automatic apply_i(input logic [31:0] instr);
        apply(instr, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; inInstruction = 0; inPostPc = 0; inRegWrite = 0;
        inWriteReg = 0; inWriteData = 0; inEX_Flush = 0;
        clk_edge();
        check("rst_reg_write", outRegWrite, 0);
        check("rst_mem_read",  outMemRead,  0);
        check("rst_alu_op",    outAluOp,    0);
        check("rst_pc",        outPc,       0);
        check("rst_rd1",       outReadData1, 0);
        check("rst_rt",        outRt,       0);
        reset = 1'b0;
        apply_i(32'h0000_0000);
        check("rst_pc_write",   outPCWrite,    1);
        check("rst_ifid_write", outIF_IDWrite, 1);
        check("rst_if_flush",   outIF_Flush,   0);
        clk_edge();

        // every register reads zero after reset
        for (int i = 1; i < 32; i++) begin
            apply_i({6'h00, 5'(i), 5'((i % 31) + 1), 5'd0, 11'h020});
            clk_edge();
            check("zero_rd1", outReadData1, 0);
            check("zero_rd2", outReadData2, 0);
        end

        // WB R5 then add r3,r5,r5
        apply(32'h0, 1'b1, 5'd5, 32'h1234, 1'b0);
        clk_edge();
        apply_i(32'h00A5_1820);
        clk_edge();
        check("add_rd1",     outReadData1, 32'h1234);
        check("add_rd2",     outReadData2, 32'h1234);
        check("add_reg_dst", outRegDst, 1);
        check("add_alu_op",  outAluOp, 2'b10);
        check("add_rd",      outRd, 5'd3);

        // same-cycle WB of the register being read
        apply(32'h00A5_1820, 1'b1, 5'd5, 32'hBEEF, 1'b0);
        clk_edge();
`ifdef WB_BYPASS_EN
        check("wb_same_cycle", outReadData1, 32'hBEEF);
`else
        check("wb_same_cycle", outReadData1, 32'h1234);
`endif
        apply_i(32'h00A5_1820);
        clk_edge();
        check("wb_next_cycle", outReadData2, 32'hBEEF);

        apply(32'h0, 1'b1, 5'd1, 32'h0000_0100, 1'b0);
        clk_edge();
        apply(32'h0, 1'b1, 5'd2, 32'h0000_0200, 1'b0);
        clk_edge();

        // lw r2,0(r1) followed by add r4,r2,r2: exactly one bubble
        apply_i(32'h8C22_0000);
        clk_edge();
        check("lw_mem_read",  outMemRead, 1);
        check("lw_mem2reg",   outMemToReg, 1);
        check("lw_alu_src",   outAluSrc, 1);
        check("lw_rd1",       outReadData1, 32'h100);
        apply_i(32'h0042_2020);
        check("stall_pc_write",   outPCWrite, 0);
        check("stall_ifid_write", outIF_IDWrite, 0);
        check("stall_if_flush",   outIF_Flush, 0);
        clk_edge();
        check("bubble_reg_write", outRegWrite, 0);
        check("bubble_reg_dst",   outRegDst, 0);
        apply_i(32'h0042_2020);
        check("post_stall_pc_write", outPCWrite, 1);
        clk_edge();
        check("post_stall_reg_dst", outRegDst, 1);
        check("post_stall_rd",      outRd, 5'd4);
        check("post_stall_rd1",     outReadData1, 32'h200);

        // lw then an instruction using the loaded reg only as rs
        apply_i(32'h8C22_0000);
        clk_edge();
        apply_i(32'h1040_0000);
        check("stall_rs_only", outPCWrite, 0);
        clk_edge();

        // j 0x40
        apply_i(32'h0800_0010);
        check("j_jump",     outJump, 1);
        check("j_if_flush", outIF_Flush, 1);
        clk_edge();
        check("j_reg_write", outRegWrite, 0);
        check("j_branch",    outBranch, 0);

        // R0 stays zero, even with a same-cycle write
        apply(32'h0000_1820, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0);
        clk_edge();
        check("r0_same_cycle", outReadData1, 0);
        apply_i(32'h0000_1820);
        clk_edge();
        check("r0_next_cycle", outReadData2, 0);

        // flush overrides a load-use stall
        apply_i(32'h8C22_0000);
        clk_edge();
        apply(32'h0042_2020, 1'b0, 5'd0, 32'h0, 1'b1);
        check("flush_pc_write",   outPCWrite, 1);
        check("flush_ifid_write", outIF_IDWrite, 1);
        check("flush_if_flush",   outIF_Flush, 1);
        check("flush_jump",       outJump, 0);
        clk_edge();
        check("flush_bubble", outRegWrite, 0);
        apply(32'h0800_0010, 1'b0, 5'd0, 32'h0, 1'b1);
        check("flush_j_jump",     outJump, 0);
        check("flush_j_if_flush", outIF_Flush, 1);
        clk_edge();

        // sw, beq, addi, unknown opcode
        apply_i(32'hAC22_0008);
        clk_edge();
        check("sw_mem_write", outMemWrite, 1);
        check("sw_reg_write", outRegWrite, 0);
        check("sw_sext",      outSignExt, 32'h8);
        apply_i(32'h1022_0004);
        clk_edge();
        check("beq_branch", outBranch, 1);
        check("beq_alu_op", outAluOp, 2'b01);
        apply_i(32'h2026_8000);
        clk_edge();
        check("addi_sext",      outSignExt, 32'hFFFF_8000);
        check("addi_alu_src",   outAluSrc, 1);
        check("addi_reg_write", outRegWrite, 1);
        check("addi_rt",        outRt, 5'd6);
        apply_i(32'hFC00_0000);
        check("op3f_jump", outJump, 0);
        clk_edge();
        check("op3f_reg_write", outRegWrite, 0);
        check("op3f_alu_src",   outAluSrc, 0);
        check("op3f_alu_op",    outAluOp, 0);

        // lw to r0 never stalls
        apply_i(32'h8C20_0000);
        clk_edge();
        check("lw_r0_mem_read", outMemRead, 1);
        apply_i(32'h0000_2020);
        check("lw_r0_no_stall", outPCWrite, 1);
        clk_edge();

        // reset in the middle of a stall
        apply_i(32'h8C22_0000);
        clk_edge();
        reset = 1'b1;
        apply_i(32'h0042_2020);
        check("pre_reset_stall", outPCWrite, 0);
        clk_edge();
        check("mid_rst_mem_read", outMemRead, 0);
        check("mid_rst_pc",       outPc, 0);
        check("mid_rst_pc_write", outPCWrite, 1);
        reset = 1'b0;
        apply_i(32'h00A5_1820);
        clk_edge();
        check("mid_rst_regs_cleared", outReadData1, 0);

        apply_i(32'h0);
        clk_edge();
        clk_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
